// File: rtl/guess_entry.sv
// Debounced confirm-button capture of a four-digit BCD guess from the switches.
// Optional GUESS_DISTINCT_CHECK_EN: also reject entries that repeat a digit.
module guess_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] switches,
  input  logic        btn,
  output logic [15:0] guess,
  output logic        confirm,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        sync1_q, sbtn_q;
  logic [15:0] guess_q, guess_d;
  logic        confirm_q, confirm_d;
  logic        error_q, error_d;
  logic        eval;

  function automatic logic entry_valid(input logic [15:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (w[4*i +: 4] > 4'd9) ok = 1'b0;
`ifdef GUESS_DISTINCT_CHECK_EN
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (w[4*i +: 4] == w[4*j +: 4]) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Saturating so a pathological parameter can never wrap back into range.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sbtn_q) begin
          state_d = ARMING;
          cnt_d   = 16'd0;
        end
      end
      ARMING: begin
        if (!sbtn_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          eval    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!sbtn_q) begin
          state_d = RELEASING;
          cnt_d   = 16'd0;
        end
      end
      RELEASING: begin
        if (sbtn_q)                state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                       cnt_d   = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    guess_d   = guess_q;
    error_d   = error_q;
    confirm_d = 1'b0;
    if (eval) begin
      if (entry_valid(switches)) begin
        guess_d   = switches;
        error_d   = 1'b0;
        confirm_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sbtn_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      guess_q   <= 16'h0000;
      confirm_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      sync1_q   <= btn;
      sbtn_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      guess_q   <= guess_d;
      confirm_q <= confirm_d;
      error_q   <= error_d;
    end
  end

  assign guess   = guess_q;
  assign confirm = confirm_q;
  assign error   = error_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with DEBOUNCE_CYCLES=4.
module tb_guess_entry;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switches;
  logic        btn;
  logic [15:0] guess;
  logic        confirm;
  logic        error;

  int tests = 0;
  int fails = 0;
  int conf_cnt = 0;
  int c0;

  guess_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .switches (switches),
    .btn      (btn),
    .guess    (guess),
    .confirm  (confirm),
    .error    (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (confirm === 1'b1) conf_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [15:0] sw, input int hold);
    switches = sw;
    btn = 1'b1;
    repeat (hold) @(negedge clock);
    btn = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; btn = 1'b0; switches = 16'h0000;
    repeat (2) @(negedge clock);
    chk("rst_guess", {16'h0, guess}, 32'h0);
    chk("rst_confirm", {31'h0, confirm}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Exact latency: confirm only after edge 6
    switches = 16'h1234; btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("lat_confirm_e%0d", i), {31'h0, confirm}, (i == 6) ? 32'h1 : 32'h0);
    end
    chk("lat_guess", {16'h0, guess}, 32'h1234);
    chk("lat_error", {31'h0, error}, 32'h0);
    btn = 1'b0;
    repeat (12) @(negedge clock);

    // Two-cycle glitch is rejected
    c0 = conf_cnt;
    switches = 16'h9999; btn = 1'b1;
    repeat (2) @(negedge clock);
    btn = 1'b0;
    repeat (6) @(negedge clock);
    chk("glitch_confirms", conf_cnt - c0, 0);
    chk("glitch_guess", {16'h0, guess}, 32'h1234);
    chk("glitch_idle", {30'h0, dut.state_q}, 32'h0);

    // Out-of-range nibble
    c0 = conf_cnt;
    press(16'h12A4, 10);
    chk("bad_confirms", conf_cnt - c0, 0);
    chk("bad_error", {31'h0, error}, 32'h1);
    chk("bad_guess", {16'h0, guess}, 32'h1234);

    c0 = conf_cnt;
    press(16'h5678, 10);
    chk("ok_confirms", conf_cnt - c0, 1);
    chk("ok_error", {31'h0, error}, 32'h0);
    chk("ok_guess", {16'h0, guess}, 32'h5678);

    // Repeated digit
    c0 = conf_cnt;
    press(16'h1123, 10);
`ifdef GUESS_DISTINCT_CHECK_EN
    chk("rep_confirms", conf_cnt - c0, 0);
    chk("rep_error", {31'h0, error}, 32'h1);
    chk("rep_guess", {16'h0, guess}, 32'h5678);
`else
    chk("rep_confirms", conf_cnt - c0, 1);
    chk("rep_error", {31'h0, error}, 32'h0);
    chk("rep_guess", {16'h0, guess}, 32'h1123);
`endif

    // Long hold, switches change while held, bouncy release
    c0 = conf_cnt;
    switches = 16'h4321; btn = 1'b1;
    repeat (20) @(negedge clock);
    switches = 16'h0000;
    repeat (30) @(negedge clock);
    btn = 1'b0; @(negedge clock);
    btn = 1'b1; @(negedge clock);
    btn = 1'b0; @(negedge clock);
    btn = 1'b1; @(negedge clock);
    btn = 1'b0;
    repeat (12) @(negedge clock);
    chk("bounce_confirms", conf_cnt - c0, 1);
    chk("bounce_guess", {16'h0, guess}, 32'h4321);
    chk("bounce_error", {31'h0, error}, 32'h0);

    // Digit boundary cases
    c0 = conf_cnt;
    press(16'h9090, 10);
    chk("b9_confirms", conf_cnt - c0, 1);
    chk("b9_guess", {16'h0, guess}, 32'h9090);
    c0 = conf_cnt;
    press(16'hF999, 10);
    chk("bF_confirms", conf_cnt - c0, 0);
    chk("bF_error", {31'h0, error}, 32'h1);
    chk("bF_guess", {16'h0, guess}, 32'h9090);

    // Reset mid-press, button stays high
    c0 = conf_cnt;
    switches = 16'h2468; btn = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("mid_rst_guess", {16'h0, guess}, 32'h0);
    chk("mid_rst_error", {31'h0, error}, 32'h0);
    chk("mid_rst_confirms", conf_cnt - c0, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("rearm_confirm_e%0d", i), {31'h0, confirm}, (i == 6) ? 32'h1 : 32'h0);
    end
    btn = 1'b0;
    repeat (12) @(negedge clock);
    chk("rearm_confirms", conf_cnt - c0, 1);
    chk("rearm_guess", {16'h0, guess}, 32'h2468);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive synchronized cycles required to accept a button level change (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port switches, input, 16 bits: four BCD digits, [15:12] most significant, assumed static while the button is pressed.
REQ-005 SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing confirm push-button, active-high.
REQ-006 SHALL have port guess, output, 16 bits: last accepted digit word, registered.
REQ-007 SHALL have port confirm, output, 1 bit: single-cycle pulse announcing a new valid guess, for the downstream game FSM.
REQ-008 SHALL have port error, output, 1 bit: level flag, the last press carried an invalid entry.

Function
REQ-009 SHALL pass btn through a two-flop synchronizer; only the synchronized level (sbtn) is used internally.
REQ-010 SHALL implement a four-state FSM: IDLE, ARMING, HELD, RELEASING.
REQ-011 IDLE: sbtn=1 -> ARMING with the counter cleared; otherwise stay.
REQ-012 ARMING: counter increments each cycle sbtn=1; sbtn=0 -> IDLE (bounce rejected); counter reaching DEBOUNCE_CYCLES-1 with sbtn=1 -> HELD and evaluate the press.
REQ-013 HELD: sbtn=0 -> RELEASING with the counter cleared; otherwise stay; no further evaluation while held.
REQ-014 RELEASING: counter increments each cycle sbtn=0; sbtn=1 -> HELD; counter reaching DEBOUNCE_CYCLES-1 -> IDLE.
REQ-015 Evaluation SHALL sample switches in the ARMING->HELD cycle; an entry is valid only if every nibble is <= 9.
REQ-016 Valid entry: guess <= sample, error <= 0, confirm = 1 for exactly the next cycle.
REQ-017 Invalid entry: guess unchanged, error <= 1, confirm stays 0.
REQ-018 confirm SHALL go high exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples btn high, when btn is held steady.
REQ-019 At most one confirm pulse SHALL be generated per debounced press, however long the button is held.
REQ-020 The counter SHALL be 16 bits wide and SHALL saturate, never wrap.
REQ-021 switches changing during HELD or RELEASING SHALL have no effect on any output.

Reset
REQ-022 Reset SHALL force: FSM=IDLE, counter=0, synchronizer flops=0, guess=16'h0000, confirm=0, error=0.
REQ-023 Reset asserted mid-press SHALL discard the press; after release, a still-held button SHALL re-arm from IDLE and confirm only after a full debounce.

Configuration
REQ-024 Macro GUESS_DISTINCT_CHECK_EN defined: validity additionally requires all four nibbles pairwise distinct, so repeated digits set error.
REQ-025 Macro GUESS_DISTINCT_CHECK_EN undefined: only the BCD range check of REQ-015 applies; repeated digits are accepted.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 switches=16'h1234, btn high and held from edge 0 -> confirm=1 only in the cycle after edge 6, guess=16'h1234, error=0.
REQ-027 btn glitches high for 2 cycles then low -> no confirm, FSM returns to IDLE, guess unchanged.
REQ-028 switches=16'h12A4 pressed -> error=1, no confirm, guess keeps its previous value; a following press with 16'h5678 -> confirm, error=0.
REQ-029 switches=16'h1123 pressed -> macro defined: error=1, no confirm; macro undefined: confirm, guess=16'h1123.
REQ-030 btn held 50 cycles with 1-cycle low bounces during release -> exactly one confirm pulse.
REQ-031 reset asserted at edge 3 of a press with btn kept high -> no confirm before edge 3+reset length+6, then exactly one confirm pulse.
